// File: rtl/regs_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regs_mp
//  Description : Multi-read-port register file with power-up clear sweep,
//                optional hardwired zero entry, write bypass and busy tracking.
//  Revision    : 1.0 - initial release
// ============================================================================

module regs_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NB_READ    = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    output logic                          ready_o,
    input  logic [NB_READ*ADDR_WIDTH-1:0] raddr_i,
    output logic [NB_READ*DATA_WIDTH-1:0] rdata_o,
    output logic [NB_READ-1:0]            rbusy_o,
    input  logic                          write_i,
    input  logic [ADDR_WIDTH-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          lock_i,
    input  logic [ADDR_WIDTH-1:0]         lock_addr_i
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        busy;
    logic                    run;
    logic                    wr_en;
    logic                    lock_en;

    assign run     = (state == RUN);
    assign ready_o = run;

    // Writes and locks to the hardwired zero entry are dropped here, so the
    // storage, busy vector and bypass path never see them.
    assign wr_en   = run && write_i && !((ZERO_REG != 0) && (waddr_i == '0));
    assign lock_en = run && lock_i  && !((ZERO_REG != 0) && (lock_addr_i == '0));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (sweep_cnt == '1) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    // Storage has no reset; its contents are only zeroed by the sweep.
    always_ff @(posedge clk_i) begin
        if (!run) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_en) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Lock is applied after the write clear so a same-cycle new producer wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else begin
            if (wr_en) begin
                busy[waddr_i] <= 1'b0;
            end
            if (lock_en) begin
                busy[lock_addr_i] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NB_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] data;
        logic                  bsy;

        assign ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (run && !((ZERO_REG != 0) && (ra == '0))) begin
                if ((BYPASS != 0) && wr_en && (waddr_i == ra)) begin
                    data = wdata_i;
                    bsy  = lock_en && (lock_addr_i == ra);
                end else begin
                    data = mem[ra];
                    bsy  = busy[ra];
                end
            end
        end

        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rbusy_o[k]                          = bsy;
    end

endmodule

`default_nettype wire
